// File: rtl/set_job_host_pkg.sv
// Shared definitions for the SET job host: mode codes, job field layout, FSM encoding.
// No logic of its own.
// Imported by the host top and its job FIFO.
package set_job_host_pkg;

   localparam int CENTRAL_W   = 24;
   localparam int RADIUS_W    = 12;
   localparam int MODE_W      = 2;
   localparam int JOB_FIXED_W = CENTRAL_W + RADIUS_W + MODE_W;

   // SET resamples its inputs this many cycles after each valid pulse
   localparam int SET_VALID_TO_READ = 2;

   localparam logic [MODE_W-1:0] SET_MODE_A   = 2'd0;
   localparam logic [MODE_W-1:0] SET_MODE_AND = 2'd1;
   localparam logic [MODE_W-1:0] SET_MODE_XOR = 2'd2;
   localparam logic [MODE_W-1:0] SET_MODE_TWO = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_RUN,
      ST_RELOAD,
      ST_READ_MIRROR,
      ST_HALT
   } host_state_t;

   // idx 0 = circle A, 1 = B, 2 = C
   function automatic logic [3:0] central_x(input logic [CENTRAL_W-1:0] c, input int idx);
      return c[CENTRAL_W-1-8*idx -: 4];
   endfunction

   function automatic logic [3:0] central_y(input logic [CENTRAL_W-1:0] c, input int idx);
      return c[CENTRAL_W-5-8*idx -: 4];
   endfunction

   function automatic logic [3:0] radius_of(input logic [RADIUS_W-1:0] r, input int idx);
      return r[RADIUS_W-1-4*idx -: 4];
   endfunction

endpackage

// File: rtl/set_job_fifo.sv
// Job descriptor FIFO, DEPTH entries of W bits, registered occupancy.
// Latency: pushed entry visible at pop_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module set_job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 42
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/set_job_host.sv
// Feeds queued jobs to one SET engine and returns each real result, tagged, on a one-entry slot.
// Latency: job accepted in IDLE -> set_en two cycles later; result one cycle after set_valid.
// Backpressure: job_ready drops when the FIFO is full; a full result slot drops new results.
module set_job_host
   import set_job_host_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [CENTRAL_W-1:0] job_central,
   input  logic [RADIUS_W-1:0]  job_radius,
   input  logic [MODE_W-1:0]    job_mode,
   input  logic [TAG_W-1:0]     job_tag,
   output logic                 set_rst,
   output logic                 set_en,
   output logic [CENTRAL_W-1:0] set_central,
   output logic [RADIUS_W-1:0]  set_radius,
   output logic [MODE_W-1:0]    set_mode,
   input  logic                 set_busy,
   input  logic                 set_valid,
   input  logic [7:0]           set_candidate,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [7:0]           res_candidate,
   output logic [TAG_W-1:0]     res_tag,
   output logic                 err_timeout,
   output logic                 err_overflow
);

   localparam int JOB_W = JOB_FIXED_W + TAG_W;
   localparam int TMR_W = $clog2(TIMEOUT + 1) + 1;
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

   host_state_t      state;
   host_state_t      state_nxt;
   logic [JOB_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [TAG_W-1:0] drive_tag;
   logic [TAG_W-1:0] inflight_tag;
   logic             inflight_live;
   logic             pend_live;
   logic [TMR_W-1:0] timer;
   logic [1:0]       rst_cnt;
   logic             rst_done;
   logic             launch_ok;
   logic             tv;
   logic             timed_out;
   logic             capture;
   logic             drain;

   assign set_rst   = (rst_cnt != 2'd0);
   assign job_ready = rst_done && !fifo_full;
   assign fifo_push = job_valid && job_ready;
   assign launch_ok = !fifo_empty && !set_rst && !set_busy;
   assign tv        = (state == ST_RUN) && set_valid;
   assign timed_out = (state == ST_RUN) && !set_valid && (timer >= TMR_LIMIT);
   assign capture   = tv && inflight_live;
   assign drain     = res_valid && res_ready;

   set_job_fifo #(.DEPTH(DEPTH), .W(JOB_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat ({job_central, job_radius, job_mode, job_tag}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:        if (launch_ok) state_nxt = ST_LAUNCH;
         ST_LAUNCH:      state_nxt = ST_RUN;
         ST_RUN: begin
            if (tv)             state_nxt = ST_RELOAD;
            else if (timed_out) state_nxt = ST_HALT;
         end
         ST_RELOAD:      state_nxt = ST_READ_MIRROR;
         ST_READ_MIRROR: state_nxt = ST_RUN;
         ST_HALT:        state_nxt = ST_IDLE;
         default:        state_nxt = ST_IDLE;
      endcase
   end

   // Drive regs only change on these two pops, so set_* is stable at every SET sample
   always_comb begin
      set_en   = 1'b0;
      fifo_pop = 1'b0;
      case (state)
         ST_IDLE:   fifo_pop = launch_ok;
         ST_LAUNCH: set_en   = 1'b1;
         ST_RUN:    fifo_pop = set_valid && !fifo_empty;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_cnt  <= 2'd2;
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (timed_out)              rst_cnt <= 2'd2;
         else if (rst_cnt != 2'd0)   rst_cnt <= rst_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         set_central   <= '0;
         set_radius    <= '0;
         set_mode      <= '0;
         drive_tag     <= '0;
         inflight_tag  <= '0;
         inflight_live <= 1'b0;
         pend_live     <= 1'b0;
         timer         <= '0;
      end else begin
         if (fifo_pop) {set_central, set_radius, set_mode, drive_tag} <= fifo_dout;
         case (state)
            ST_LAUNCH: begin
               inflight_tag  <= drive_tag;
               inflight_live <= 1'b1;
               timer         <= '0;
            end
            ST_RUN: begin
               if (tv) pend_live <= !fifo_empty;
               else    timer     <= timer + 1'b1;
            end
            // A rerun with no fresh job is a phantom: its result must be dropped
            ST_READ_MIRROR: begin
               inflight_live <= pend_live;
               inflight_tag  <= drive_tag;
               timer         <= '0;
            end
            ST_HALT:   inflight_live <= 1'b0;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid     <= 1'b0;
         res_candidate <= '0;
         res_tag       <= '0;
         err_overflow  <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         if (capture && (!res_valid || drain)) begin
            res_valid     <= 1'b1;
            res_candidate <= set_candidate;
            res_tag       <= inflight_tag;
         end else if (capture) begin
            err_overflow  <= 1'b1;
         end else if (drain) begin
            res_valid     <= 1'b0;
         end
         if (timed_out) err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_set_job_host.sv
// Bench for set_job_host paired with a behavioural SET engine (16x16 grid circle counter).
module tb_set_job_host;

   localparam int SET_LAT = 327;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [23:0] job_central;
   logic [11:0] job_radius;
   logic [1:0]  job_mode;
   logic [3:0]  job_tag;
   logic        set_rst;
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy;
   logic        set_valid;
   logic [7:0]  set_candidate;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_candidate;
   logic [3:0]  res_tag;
   logic        err_timeout;
   logic        err_overflow;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int en_cnt = 0;
   int hs_cnt = 0;
   int k = 0;
   logic [7:0] set_cnt_q = 8'd0;
   bit silent = 1'b0;

   set_job_host #(.DEPTH(4), .TAG_W(4), .TIMEOUT(1023)) dut (
      .clk           (clk),
      .rst           (rst),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_central   (job_central),
      .job_radius    (job_radius),
      .job_mode      (job_mode),
      .job_tag       (job_tag),
      .set_rst       (set_rst),
      .set_en        (set_en),
      .set_central   (set_central),
      .set_radius    (set_radius),
      .set_mode      (set_mode),
      .set_busy      (set_busy),
      .set_valid     (set_valid),
      .set_candidate (set_candidate),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_candidate (res_candidate),
      .res_tag       (res_tag),
      .err_timeout   (err_timeout),
      .err_overflow  (err_overflow)
   );

   always #5 clk = ~clk;

   function automatic bit in_circle(input int x, input int y, input logic [3:0] cx,
                                    input logic [3:0] cy, input logic [3:0] r);
      int dx;
      int dy;
      dx = x - int'(cx);
      dy = y - int'(cy);
      return (dx * dx + dy * dy) <= int'(r) * int'(r);
   endfunction

   // Candidate count over the 16x16 grid, straight from the mode definitions
   function automatic logic [7:0] ref_count(input logic [23:0] c, input logic [11:0] r,
                                            input logic [1:0] m);
      int n;
      n = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            bit a, b, e, hit;
            a = in_circle(x, y, c[23:20], c[19:16], r[11:8]);
            b = in_circle(x, y, c[15:12], c[11:8],  r[7:4]);
            e = in_circle(x, y, c[7:4],   c[3:0],   r[3:0]);
            case (m)
               2'd0:    hit = a;
               2'd1:    hit = a && b;
               2'd2:    hit = a ^ b;
               default: hit = (int'(a) + int'(b) + int'(e)) == 2;
            endcase
            if (hit) n++;
         end
      end
      return n[7:0];
   endfunction

   // SET engine: READ the cycle after en, valid SET_LAT cycles after en, reREAD two cycles after valid
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (set_en) en_cnt <= en_cnt + 1;
      if (res_valid && res_ready) hs_cnt <= hs_cnt + 1;
      if (set_rst) k <= 0;
      else if (k == 0) begin
         if (set_en) k <= 1;
      end else if (k == 1) begin
         set_cnt_q <= ref_count(set_central, set_radius, set_mode);
         k <= 2;
      end else if (k == SET_LAT + 1) k <= 1;
      else k <= k + 1;
   end

   assign set_valid     = (k == SET_LAT) && !silent;
   assign set_busy      = (k != 0);
   assign set_candidate = set_cnt_q;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input logic [3:0] t);
      int n;
      n = 0;
      job_valid = 1'b1; job_central = c; job_radius = r; job_mode = m; job_tag = t;
      while (job_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", job_ready, 1'b1);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic expect_result(input logic [7:0] cand, input logic [3:0] tag, input string name);
      int n;
      n = 0;
      while (res_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_vld"}, res_valid, 1'b1);
      check({name, "_cand"}, res_candidate, cand);
      check({name, "_tag"}, res_tag, tag);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      logic [23:0] rc [4];
      logic [11:0] rr [4];
      logic [1:0]  rm [4];
      int e0, h0, t0, n;

      rst = 1'b0; job_valid = 1'b0; job_central = '0; job_radius = '0;
      job_mode = '0; job_tag = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_set_rst", set_rst, 1'b1);
      check("rst_set_en", set_en, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_job_ready", job_ready, 1'b0);
      check("rst_errs", {err_timeout, err_overflow}, 2'b00);
      check("rst_drive", {set_central, set_radius, set_mode}, 38'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_set_rst_hold", set_rst, 1'b1);
      @(negedge clk);
      check("rel_set_rst_drop", set_rst, 1'b0);
      check("rel_job_ready", job_ready, 1'b1);

      // single mode-0 job, A=(4,4) r=2
      e0 = en_cnt;
      push_job(24'h440000, 12'h200, 2'd0, 4'd3);
      check("t1_en_not_yet", set_en, 1'b0);
      @(negedge clk);
      check("t1_en_pulse", set_en, 1'b1);
      check("t1_drive", {set_central, set_radius, set_mode}, {24'h440000, 12'h200, 2'd0});
      expect_result(8'd13, 4'd3, "t1");
      check("t1_en_count", en_cnt - e0, 1);

      // chained jobs through the valid->READ path, no further en pulses
      e0 = en_cnt;
      push_job(24'h444400, 12'h220, 2'd1, 4'd1);
      push_job(24'h444400, 12'h220, 2'd2, 4'd2);
      expect_result(8'd13, 4'd1, "t2_and");
      expect_result(8'd0, 4'd2, "t2_xor");
      check("t2_no_gap_en", en_cnt - e0, 0);

      // phantom reruns must stay invisible
      n = 0;
      repeat (700) begin
         @(negedge clk);
         if (res_valid) n++;
      end
      check("t3_phantom_vld", n, 0);
      check("t3_total_results", hs_cnt, 3);

      // two results with the consumer stalled
      for (int i = 0; i < 2; i++) begin
         rc[i] = 24'($urandom);
         rr[i] = {4'($urandom_range(2, 6)), 4'($urandom_range(2, 6)), 4'($urandom_range(2, 6))};
         rm[i] = 2'($urandom_range(0, 3));
      end
      check("t4_ovf_clear", err_overflow, 1'b0);
      push_job(rc[0], rr[0], rm[0], 4'd4);
      push_job(rc[1], rr[1], rm[1], 4'd5);
      n = 0;
      while (err_overflow !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t4_ovf_set", err_overflow, 1'b1);
      check("t4_slot_held", res_valid, 1'b1);
      expect_result(ref_count(rc[0], rr[0], rm[0]), 4'd4, "t4_first");
      check("t4_second_dropped", res_valid, 1'b0);

      // random jobs, results in order
      for (int i = 0; i < 3; i++) begin
         rc[i] = 24'($urandom);
         rr[i] = {4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)), 4'($urandom_range(1, 6))};
         rm[i] = 2'($urandom_range(0, 3));
         push_job(rc[i], rr[i], rm[i], 4'(6 + i));
      end
      for (int i = 0; i < 3; i++)
         expect_result(ref_count(rc[i], rr[i], rm[i]), 4'(6 + i), "t5_rand");

      // reset in the middle of a run with another job queued
      check("t6_ovf_sticky", err_overflow, 1'b1);
      push_job(24'h123456, 12'h345, 2'd3, 4'd10);
      push_job(24'h654321, 12'h543, 2'd1, 4'd11);
      n = 0;
      while (set_central !== 24'h123456 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("t6_x_loaded", set_central, 24'h123456);
      repeat (50) @(negedge clk);
      rst = 1'b0;
      #1;
      check("t6_set_rst", set_rst, 1'b1);
      check("t6_set_en", set_en, 1'b0);
      check("t6_drive", {set_central, set_radius, set_mode}, 38'd0);
      check("t6_res", {res_valid, res_candidate, res_tag}, 13'd0);
      check("t6_job_ready", job_ready, 1'b0);
      check("t6_errs", {err_timeout, err_overflow}, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_set_rst_rel", set_rst, 1'b0);
      h0 = hs_cnt;
      push_job(24'h884400, 12'h330, 2'd1, 4'd12);
      expect_result(ref_count(24'h884400, 12'h330, 2'd1), 4'd12, "t6_recover");
      check("t6_one_result", hs_cnt - h0, 1);

      // SET goes silent: timeout, SET reset pulse, queued jobs then complete
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t7_errs_clear", {err_timeout, err_overflow}, 2'b00);
      silent = 1'b1;
      push_job(24'h777700, 12'h500, 2'd0, 4'd5);
      n = 0;
      while (set_en !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t7_launch", set_en, 1'b1);
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         rc[i] = 24'($urandom);
         rr[i] = {4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)), 4'($urandom_range(1, 6))};
         rm[i] = 2'($urandom_range(0, 3));
         push_job(rc[i], rr[i], rm[i], 4'(6 + i));
      end
      check("t7_fifo_full", job_ready, 1'b0);
      job_valid = 1'b1; job_tag = 4'hf;
      @(negedge clk);
      job_valid = 1'b0;
      n = 0;
      while (err_timeout !== 1'b1 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      check("t7_timeout_set", err_timeout, 1'b1);
      check("t7_timeout_cycle", cyc - t0, 1025);
      check("t7_halt_rst0", set_rst, 1'b1);
      silent = 1'b0;
      @(negedge clk);
      check("t7_halt_rst1", set_rst, 1'b1);
      @(negedge clk);
      check("t7_halt_rst2", set_rst, 1'b0);
      h0 = hs_cnt;
      for (int i = 0; i < 4; i++)
         expect_result(ref_count(rc[i], rr[i], rm[i]), 4'(6 + i), "t7_job");
      check("t7_result_count", hs_cnt - h0, 4);
      check("t7_timeout_sticky", err_timeout, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
